fir_xifu_scoreboard: RTL

Parametrised in-flight instruction tracker for the FIR XIF unit, replacing the flat issue/commit/kill/clear bit-vectors with a per-ID state machine plus register-hazard reservation. It sits between the ID stage (issue handshake), the core's XIF commit interface and the WB stage (clear). It drives the per-ID `issue`/`commit`/`kill` vectors consumed by EX and WB, and stalls issue on RAW/WAW hazards against the XIFU private register file.

---
 rtl/fir_xifu_pkg.sv | 34 +++
 rtl/fir_xifu_scoreboard_if.sv | 47 ++++
 rtl/fir_xifu_sb_slot.sv | 74 +++++++
 rtl/fir_xifu_scoreboard.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIF unit: slot-state encoding and the
// ID->scoreboard / scoreboard->EX bundles in their default configuration.
package fir_xifu_pkg;

    localparam int unsigned XIFU_X_ID_WIDTH = 4;
    localparam int unsigned XIFU_X_ID_MAX   = 2 ** XIFU_X_ID_WIDTH;
    localparam int unsigned XIFU_NUM_REGS   = 32;
    localparam int unsigned XIFU_REG_AW     = $clog2(XIFU_NUM_REGS);

    // Lifecycle of one in-flight instruction ID
    typedef enum logic [1:0] {
        SLOT_FREE      = 2'b00,
        SLOT_ISSUED    = 2'b01,
        SLOT_COMMITTED = 2'b10
    } fir_xifu_slot_state_t;

    // Issue request from the ID stage
    typedef struct packed {
        logic                         valid;
        logic [XIFU_X_ID_WIDTH-1:0]   id;
        logic [2*XIFU_REG_AW-1:0]     rs;
        logic [1:0]                   rs_use;
        logic [XIFU_REG_AW-1:0]       rd;
        logic                         rd_we;
    } fir_xifu_id2sb_t;

    // Per-ID status vectors consumed by EX and WB
    typedef struct packed {
        logic [XIFU_X_ID_MAX-1:0] issued;
        logic [XIFU_X_ID_MAX-1:0] committed;
        logic [XIFU_X_ID_MAX-1:0] killed;
    } fir_xifu_sb2ex_t;

endpackage

// File: rtl/fir_xifu_scoreboard_if.sv
// Issue / commit / clear bus between ID, core XIF, WB and the scoreboard.
interface fir_xifu_scoreboard_if #(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned NUM_REGS   = 32
);
    localparam int unsigned X_ID_MAX = 2 ** X_ID_WIDTH;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);

    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [X_ID_WIDTH-1:0] issue_id_i;
    logic [2*REG_AW-1:0]   issue_rs_i;
    logic [1:0]            issue_rs_use_i;
    logic [REG_AW-1:0]     issue_rd_i;
    logic                  issue_rd_we_i;
    logic                  commit_valid_i;
    logic [X_ID_WIDTH-1:0] commit_id_i;
    logic                  commit_kill_i;
    logic                  clear_valid_i;
    logic [X_ID_WIDTH-1:0] clear_id_i;
    logic [X_ID_MAX-1:0]   issued_o;
    logic [X_ID_MAX-1:0]   committed_o;
    logic [X_ID_MAX-1:0]   killed_o;
    logic [X_ID_WIDTH:0]   inflight_o;
    logic                  err_o;

    // Pipeline side: drives events, observes tracker status
    modport master (
        output issue_valid_i, issue_id_i, issue_rs_i, issue_rs_use_i,
               issue_rd_i, issue_rd_we_i,
               commit_valid_i, commit_id_i, commit_kill_i,
               clear_valid_i, clear_id_i,
        input  issue_ready_o, issued_o, committed_o, killed_o,
               inflight_o, err_o
    );

    // Scoreboard side
    modport slave (
        input  issue_valid_i, issue_id_i, issue_rs_i, issue_rs_use_i,
               issue_rd_i, issue_rd_we_i,
               commit_valid_i, commit_id_i, commit_kill_i,
               clear_valid_i, clear_id_i,
        output issue_ready_o, issued_o, committed_o, killed_o,
               inflight_o, err_o
    );

endinterface

// File: rtl/fir_xifu_sb_slot.sv
// Single instruction-ID tracker: FREE/ISSUED/COMMITTED FSM holding the
// destination register of the instruction that owns the slot. Illegal
// events for the current state are ignored here; the top flags them.
module fir_xifu_sb_slot
    import fir_xifu_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_issue,
    input  logic                 i_commit,
    input  logic                 i_kill,
    input  logic                 i_clear,
    input  logic [REG_AW-1:0]    i_rd,
    input  logic                 i_rd_we,
    output fir_xifu_slot_state_t o_state,
    output logic [REG_AW-1:0]    o_rd,
    output logic                 o_rd_we,
    output logic                 o_clear_done,
    output logic                 o_kill_done,
    output logic                 o_killed
);

    fir_xifu_slot_state_t r_state;
    fir_xifu_slot_state_t w_state_nxt;
    logic [REG_AW-1:0]    r_rd;
    logic                 r_rd_we;
    logic                 r_killed;
    logic                 w_clear_done;
    logic                 w_kill_done;

    // State register, captured rd payload and registered kill pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= SLOT_FREE;
            r_rd     <= '0;
            r_rd_we  <= 1'b0;
            r_killed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_killed <= w_kill_done;
            if (i_issue && (r_state == SLOT_FREE)) begin
                r_rd    <= i_rd;
                r_rd_we <= i_rd_we;
            end
        end
    end

    // Next-state: only the legal transition for each state is honoured
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SLOT_FREE:      if (i_issue)  w_state_nxt = SLOT_ISSUED;
            SLOT_ISSUED:    if (i_commit) w_state_nxt = i_kill ? SLOT_FREE : SLOT_COMMITTED;
            SLOT_COMMITTED: if (i_clear)  w_state_nxt = SLOT_FREE;
            default:                      w_state_nxt = SLOT_FREE;
        endcase
    end

    // Release strobes: slot leaves via retire (clear) or kill this cycle
    always_comb begin
        w_clear_done = (r_state == SLOT_COMMITTED) && i_clear;
        w_kill_done  = (r_state == SLOT_ISSUED) && i_commit && i_kill;
    end

    assign o_state      = r_state;
    assign o_rd         = r_rd;
    assign o_rd_we      = r_rd_we;
    assign o_clear_done = w_clear_done;
    assign o_kill_done  = w_kill_done;
    assign o_killed     = r_killed;

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// In-flight instruction tracker for the FIR XIF unit. One FSM per ID plus
// register-hazard reservation (pending vector) gating issue on RAW/WAW.
// Optional: define FIR_XIFU_SCOREBOARD_ERR_EN for sticky protocol-error
// detection on err_o; otherwise err_o is 0 and illegal events are ignored.
module fir_xifu_scoreboard
    import fir_xifu_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    fir_xifu_scoreboard_if.slave        sb_if
);

    localparam int unsigned X_ID_MAX = 2 ** X_ID_WIDTH;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);

    fir_xifu_slot_state_t w_state   [X_ID_MAX];
    logic [REG_AW-1:0]    w_slot_rd [X_ID_MAX];
    logic [X_ID_MAX-1:0]  w_slot_rd_we;
    logic [X_ID_MAX-1:0]  w_clear_done;
    logic [X_ID_MAX-1:0]  w_kill_done;
    logic [X_ID_MAX-1:0]  w_killed;
    logic [X_ID_MAX-1:0]  w_issued;
    logic [X_ID_MAX-1:0]  w_committed;

    logic [NUM_REGS-1:0]  r_pending;
    logic [NUM_REGS-1:0]  w_pending_nxt;
    logic [X_ID_WIDTH:0]  r_inflight;
    logic [X_ID_WIDTH:0]  w_inflight_nxt;

    logic [REG_AW-1:0]    w_rs1;
    logic [REG_AW-1:0]    w_rs2;
    logic                 w_rs1_busy;
    logic                 w_rs2_busy;
    logic                 w_rd_busy;
    logic                 w_issue_ready;
    logic                 w_issue_hs;

    // Issue gating from registered state only: free slot, no RAW/WAW hazard
    always_comb begin
        w_rs1         = sb_if.issue_rs_i[REG_AW-1:0];
        w_rs2         = sb_if.issue_rs_i[2*REG_AW-1:REG_AW];
        w_rs1_busy    = sb_if.issue_rs_use_i[0] && r_pending[w_rs1];
        w_rs2_busy    = sb_if.issue_rs_use_i[1] && r_pending[w_rs2];
        w_rd_busy     = sb_if.issue_rd_we_i && r_pending[sb_if.issue_rd_i];
        w_issue_ready = (w_state[sb_if.issue_id_i] == SLOT_FREE) &&
                        !w_rs1_busy && !w_rs2_busy && !w_rd_busy;
    end

    assign w_issue_hs = sb_if.issue_valid_i && w_issue_ready;

    for (genvar g = 0; g < X_ID_MAX; g++) begin : g_slot
        fir_xifu_sb_slot #(
            .REG_AW (REG_AW)
        ) u_slot (
            .i_clk        (clk_i),
            .i_rst        (rst_i),
            .i_issue      (w_issue_hs && (sb_if.issue_id_i == X_ID_WIDTH'(g))),
            .i_commit     (sb_if.commit_valid_i && (sb_if.commit_id_i == X_ID_WIDTH'(g))),
            .i_kill       (sb_if.commit_kill_i),
            .i_clear      (sb_if.clear_valid_i && (sb_if.clear_id_i == X_ID_WIDTH'(g))),
            .i_rd         (sb_if.issue_rd_i),
            .i_rd_we      (sb_if.issue_rd_we_i),
            .o_state      (w_state[g]),
            .o_rd         (w_slot_rd[g]),
            .o_rd_we      (w_slot_rd_we[g]),
            .o_clear_done (w_clear_done[g]),
            .o_kill_done  (w_kill_done[g]),
            .o_killed     (w_killed[g])
        );
        assign w_issued[g]    = (w_state[g] != SLOT_FREE);
        assign w_committed[g] = (w_state[g] == SLOT_COMMITTED);
    end

    // Pending next value: releases first, then the new reservation. An issue
    // cannot target a register being released since that register is still
    // pending and would have blocked the handshake.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int unsigned s = 0; s < X_ID_MAX; s++) begin
            if ((w_clear_done[s] || w_kill_done[s]) && w_slot_rd_we[s]) begin
                w_pending_nxt[w_slot_rd[s]] = 1'b0;
            end
        end
        if (w_issue_hs && sb_if.issue_rd_we_i) begin
            w_pending_nxt[sb_if.issue_rd_i] = 1'b1;
        end
    end

    // Occupancy: at most one issue in, one clear and one kill out per cycle
    always_comb begin
        w_inflight_nxt = r_inflight
                       + (X_ID_WIDTH+1)'(w_issue_hs)
                       - (X_ID_WIDTH+1)'(|w_clear_done)
                       - (X_ID_WIDTH+1)'(|w_kill_done);
    end

    // Register reservation vector and occupancy counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending  <= '0;
            r_inflight <= '0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_inflight <= w_inflight_nxt;
        end
    end

`ifdef FIR_XIFU_SCOREBOARD_ERR_EN
    logic r_err;
    logic w_err_evt;

    // Illegal event: commit/kill of a non-ISSUED slot, clear of a non-COMMITTED slot
    always_comb begin
        w_err_evt = (sb_if.commit_valid_i && (w_state[sb_if.commit_id_i] != SLOT_ISSUED)) ||
                    (sb_if.clear_valid_i  && (w_state[sb_if.clear_id_i]  != SLOT_COMMITTED));
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign sb_if.err_o = r_err;
`else
    assign sb_if.err_o = 1'b0;
`endif

    assign sb_if.issue_ready_o = w_issue_ready;
    assign sb_if.issued_o      = w_issued;
    assign sb_if.committed_o   = w_committed;
    assign sb_if.killed_o      = w_killed;
    assign sb_if.inflight_o    = r_inflight;

endmodule
